// File: rtl/bram_pkg.sv
// Shared types and the byte-lane merge helper for the byte-enable block RAM.
package bram_pkg;

    // Behaviour of the read-data stage when the access is a write.
    typedef enum logic [1:0] {
        WM_READ_FIRST,
        WM_WRITE_FIRST,
        WM_NO_CHANGE
    } write_mode_e;

    // Post-reset clear sequencer states.
    typedef enum logic {
        CLR_CLEAR,
        CLR_READY
    } clr_state_e;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int MERGE_MAX_WIDTH = 256;

    // Bits of lanes with be set come from new_word, the rest from old_word.
    // One enable bit per lane, so the enable vector never needs more bits
    // than the word itself.
    function automatic logic [MERGE_MAX_WIDTH-1:0] bram_merge(
        input logic [MERGE_MAX_WIDTH-1:0] old_word,
        input logic [MERGE_MAX_WIDTH-1:0] new_word,
        input logic [MERGE_MAX_WIDTH-1:0] be,
        input int                         byte_width
    );
        logic [MERGE_MAX_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MERGE_MAX_WIDTH; i++) begin
            if (be[8'(i / byte_width)]) begin
                merged[8'(i)] = new_word[8'(i)];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/bram_clear_fsm.sv
// Post-reset clear sequencer: walks every address once, requesting an
// all-zero write per cycle, then reports ready for normal accesses.
module bram_clear_fsm
    import bram_pkg::*;
#(
    parameter int RAM_ADDR_BITS  = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     busy_o,
    output logic                     clr_we_o,
    output logic [RAM_ADDR_BITS-1:0] clr_addr_o
);

    clr_state_e               state;
    logic [RAM_ADDR_BITS-1:0] cnt;
    logic                     busy_q;

    // State, address counter and the registered busy flag advance together;
    // reset always restarts the sweep from address 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= (CLEAR_ON_RESET != 0) ? CLR_CLEAR : CLR_READY;
            busy_q <= (CLEAR_ON_RESET != 0);
            cnt    <= '0;
        end else begin
            case (state)
                CLR_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state  <= CLR_READY;
                        busy_q <= 1'b0;
                    end
                end
                CLR_READY: begin
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = cnt;

endmodule

// File: rtl/bram_1p_be_pipe.sv
// Single-port block RAM with per-lane write enables, selectable write mode,
// optional output register and a post-reset zeroing sweep.
//
// Output handshake: valid_o is a one-cycle pulse; whenever it is 1, data_o
// carries a word that has not been presented before. There is no back
// pressure; with OUT_REG=1 the consumer paces the output via reg_en_i.
// Requests (en_i) arriving while busy_o=1 are discarded, not queued.
module bram_1p_be_pipe
    import bram_pkg::*;
#(
    parameter int          RAM_WIDTH      = 32,
    parameter int          RAM_ADDR_BITS  = 4,
    parameter int          BYTE_WIDTH     = 8,
    parameter int          OUT_REG        = 1,
    parameter write_mode_e WRITE_MODE     = WM_READ_FIRST,
    parameter int          CLEAR_ON_RESET = 1,
    localparam int         NB             = RAM_WIDTH / BYTE_WIDTH,
    localparam int         RAM_DEPTH      = 2 ** RAM_ADDR_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [NB-1:0]            we_i,
    input  logic [RAM_ADDR_BITS-1:0] addr_i,
    input  logic [RAM_WIDTH-1:0]     data_i,
    input  logic                     reg_en_i,
    output logic [RAM_WIDTH-1:0]     data_o,
    output logic                     valid_o,
    output logic                     busy_o
);

    logic                     busy;
    logic                     clr_we;
    logic [RAM_ADDR_BITS-1:0] clr_addr;

    bram_clear_fsm #(
        .RAM_ADDR_BITS  (RAM_ADDR_BITS),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign busy_o = busy;

    logic [RAM_WIDTH-1:0]     mem [RAM_DEPTH];
    logic                     access;
    logic                     is_write;
    logic                     s1_load;
    logic [RAM_ADDR_BITS-1:0] port_addr;
    logic [NB-1:0]            port_we;
    logic [RAM_WIDTH-1:0]     port_din;
    logic [RAM_WIDTH-1:0]     old_word;
    logic [RAM_WIDTH-1:0]     merged_word;
    logic [RAM_WIDTH-1:0]     s1_data;
    logic                     valid_q;

    assign access   = en_i & ~busy;
    assign is_write = |we_i;
    // NO_CHANGE writes leave the read stage untouched.
    assign s1_load  = access & (~is_write | (WRITE_MODE != WM_NO_CHANGE));

    // The clear sweep owns the single array port while busy.
    assign port_addr = clr_we ? clr_addr : addr_i;
    assign port_we   = clr_we ? '1 : (access ? we_i : '0);
    assign port_din  = clr_we ? '0 : data_i;

    assign old_word    = mem[port_addr];
    assign merged_word = RAM_WIDTH'(bram_merge(MERGE_MAX_WIDTH'(old_word),
                                               MERGE_MAX_WIDTH'(data_i),
                                               MERGE_MAX_WIDTH'(we_i),
                                               BYTE_WIDTH));

    // Byte-lane writes into the array; reset deliberately leaves it alone.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (port_we[b]) begin
                mem[port_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= port_din[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Stage-1 read data: old word, or the merged word for WRITE_FIRST writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_data <= '0;
        end else if (s1_load) begin
            s1_data <= (is_write && (WRITE_MODE == WM_WRITE_FIRST)) ? merged_word : old_word;
        end
    end

    generate
        if (OUT_REG == 0) begin : g_no_oreg
            logic unused_reg_en;
            assign unused_reg_en = reg_en_i;

            // Valid pulse follows every access that refreshed stage-1.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= s1_load;
                end
            end

            assign data_o = s1_data;
        end else begin : g_oreg
            logic                 v1;
            logic [RAM_WIDTH-1:0] out_q;

            // Output register loads on reg_en_i; v1 marks unconsumed stage-1 data
            // and a fresh access wins over the consume in the same cycle.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    v1      <= 1'b0;
                    out_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    if (s1_load) begin
                        v1 <= 1'b1;
                    end else if (reg_en_i) begin
                        v1 <= 1'b0;
                    end
                    if (reg_en_i) begin
                        out_q   <= s1_data;
                        valid_q <= v1;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
            end

            assign data_o = out_q;
        end
    endgenerate

    assign valid_o = valid_q;

endmodule

// File: tb/tb_bram_1p_be_pipe.sv
// Bench for bram_1p_be_pipe: three OUT_REG=0 instances (one per write mode)
// and one OUT_REG=1 instance share the same stimulus.
module tb_bram_1p_be_pipe;
    import bram_pkg::*;

    localparam int W     = 32;
    localparam int A     = 3;
    localparam int NB    = 4;
    localparam int DEPTH = 8;

    // Clock and reset
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          rst_i    = 1'b1;
    logic          en_i     = 1'b0;
    logic          reg_en_i = 1'b0;
    logic [NB-1:0] we_i     = '0;
    logic [A-1:0]  addr_i   = '0;
    logic [W-1:0]  data_i   = '0;

    logic [W-1:0] d_rf, d_wf, d_nc, d_or;
    logic         v_rf, v_wf, v_nc, v_or;
    logic         b_rf, b_wf, b_nc, b_or;

    bram_1p_be_pipe #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A), .BYTE_WIDTH(8), .OUT_REG(0),
                      .WRITE_MODE(WM_READ_FIRST), .CLEAR_ON_RESET(1)) u_rf (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .reg_en_i(reg_en_i), .data_o(d_rf), .valid_o(v_rf), .busy_o(b_rf));

    bram_1p_be_pipe #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A), .BYTE_WIDTH(8), .OUT_REG(0),
                      .WRITE_MODE(WM_WRITE_FIRST), .CLEAR_ON_RESET(1)) u_wf (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .reg_en_i(reg_en_i), .data_o(d_wf), .valid_o(v_wf), .busy_o(b_wf));

    bram_1p_be_pipe #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A), .BYTE_WIDTH(8), .OUT_REG(0),
                      .WRITE_MODE(WM_NO_CHANGE), .CLEAR_ON_RESET(1)) u_nc (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .reg_en_i(reg_en_i), .data_o(d_nc), .valid_o(v_nc), .busy_o(b_nc));

    bram_1p_be_pipe #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A), .BYTE_WIDTH(8), .OUT_REG(1),
                      .WRITE_MODE(WM_READ_FIRST), .CLEAR_ON_RESET(1)) u_or (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .reg_en_i(reg_en_i), .data_o(d_or), .valid_o(v_or), .busy_o(b_or));

    // Scoreboard state
    logic [W-1:0] q_rf[$];
    logic [W-1:0] q_wf[$];
    logic [W-1:0] q_nc[$];
    logic [W-1:0] q_or[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    logic [W-1:0] mdl [DEPTH];
    logic [W-1:0] s1_m     = '0;
    logic         v1_m     = 1'b0;
    logic         busy_exp = 1'b1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] merge_model(input logic [W-1:0] old_w,
                                                  input logic [W-1:0] new_w,
                                                  input logic [NB-1:0] we);
        logic [W-1:0] mask;
        mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Driver: predicts responses, applies one request, advances one edge
    task automatic cycle(input logic en, input logic [NB-1:0] we, input logic [A-1:0] addr,
                         input logic [W-1:0] data, input logic reg_en);
        logic         acc;
        logic         wr;
        logic [W-1:0] old_w;
        logic [W-1:0] mrg;
        acc   = en && !busy_exp;
        wr    = |we;
        old_w = mdl[addr];
        mrg   = merge_model(old_w, data, we);
        if (acc) begin
            q_rf.push_back(old_w);
            q_wf.push_back(wr ? mrg : old_w);
            if (!wr) q_nc.push_back(old_w);
        end
        if (reg_en && v1_m) q_or.push_back(s1_m);
        if (acc) begin
            s1_m = old_w;
            v1_m = 1'b1;
        end else if (reg_en) begin
            v1_m = 1'b0;
        end
        if (acc && wr) mdl[addr] = mrg;
        en_i     = en;
        we_i     = we;
        addr_i   = addr;
        data_i   = data;
        reg_en_i = reg_en;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_i    = 1'b1;
        en_i     = 1'b0;
        we_i     = '0;
        reg_en_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
        rst_i    = 1'b0;
        s1_m     = '0;
        v1_m     = 1'b0;
        busy_exp = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    // Eight busy cycles with a read of addr 5 held on en_i, all dropped
    task automatic clear_wait();
        for (int i = 0; i < DEPTH; i++) begin
            check("busy_during_clear", 32'({b_rf, b_wf, b_nc, b_or}), 32'hF);
            cycle(1'b1, 4'h0, 3'd5, 32'h0, 1'b1);
        end
        busy_exp = 1'b0;
        check("busy_after_clear", 32'({b_rf, b_wf, b_nc, b_or}), 32'h0);
    endtask

    // Monitors: pop and compare whenever an instance presents valid data
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && v_rf === 1'b1) begin
            if (q_rf.size() == 0) check("rf_unexpected_valid", 32'(v_rf), 32'h0);
            else check("rf_data", d_rf, q_rf.pop_front());
        end
    end

    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && v_wf === 1'b1) begin
            if (q_wf.size() == 0) check("wf_unexpected_valid", 32'(v_wf), 32'h0);
            else check("wf_data", d_wf, q_wf.pop_front());
        end
    end

    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && v_nc === 1'b1) begin
            if (q_nc.size() == 0) check("nc_unexpected_valid", 32'(v_nc), 32'h0);
            else check("nc_data", d_nc, q_nc.pop_front());
        end
    end

    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && v_or === 1'b1) begin
            if (q_or.size() == 0) check("or_unexpected_valid", 32'(v_or), 32'h0);
            else check("or_data", d_or, q_or.pop_front());
        end
    end

    // Directed sequence
    initial begin
        // Reset state
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        check("reset_data_rf", d_rf, 32'h0);
        check("reset_data_wf", d_wf, 32'h0);
        check("reset_data_nc", d_nc, 32'h0);
        check("reset_data_or", d_or, 32'h0);
        check("reset_valid", 32'({v_rf, v_wf, v_nc, v_or}), 32'h0);
        check("reset_busy", 32'({b_rf, b_wf, b_nc, b_or}), 32'hF);
        rst_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

        // Clear sweep, then the first accepted read of addr 5
        clear_wait();
        cycle(1'b1, 4'h0, 3'd5, 32'h0, 1'b1);
        check("clear_read5_data", d_rf, 32'h0000_0000);
        check("clear_read5_valid", 32'(v_rf), 32'h1);

        // Byte-lane write
        cycle(1'b1, 4'hF, 3'd2, 32'hAABB_CCDD, 1'b1);
        cycle(1'b1, 4'b0101, 3'd2, 32'h1122_3344, 1'b1);
        cycle(1'b1, 4'h0, 3'd2, 32'h0, 1'b1);
        check("byte_merge", d_rf, 32'hAA22_CC44);

        // Write modes
        cycle(1'b1, 4'hF, 3'd1, 32'h1234_5678, 1'b1);
        cycle(1'b1, 4'hF, 3'd1, 32'hFFFF_FFFF, 1'b1);
        check("read_first_data", d_rf, 32'h1234_5678);
        check("read_first_valid", 32'(v_rf), 32'h1);
        check("write_first_data", d_wf, 32'hFFFF_FFFF);
        check("write_first_valid", 32'(v_wf), 32'h1);
        check("no_change_data", d_nc, 32'hAA22_CC44);
        check("no_change_valid", 32'(v_nc), 32'h0);

        // Output register paced by reg_en_i
        cycle(1'b1, 4'hF, 3'd3, 32'h0000_BEEF, 1'b1);
        cycle(1'b0, 4'h0, 3'd0, 32'h0, 1'b1);
        cycle(1'b0, 4'h0, 3'd0, 32'h0, 1'b1);
        cycle(1'b1, 4'h0, 3'd3, 32'h0, 1'b0);
        check("oreg_hold1", d_or, 32'h0);
        cycle(1'b0, 4'h0, 3'd0, 32'h0, 1'b0);
        check("oreg_hold2", d_or, 32'h0);
        cycle(1'b0, 4'h0, 3'd0, 32'h0, 1'b0);
        check("oreg_hold3", d_or, 32'h0);
        cycle(1'b0, 4'h0, 3'd0, 32'h0, 1'b1);
        check("oreg_load_data", d_or, 32'h0000_BEEF);
        check("oreg_load_valid", 32'(v_or), 32'h1);
        cycle(1'b0, 4'h0, 3'd0, 32'h0, 1'b1);
        check("oreg_reload_data", d_or, 32'h0000_BEEF);
        check("oreg_reload_valid", 32'(v_or), 32'h0);

        // Pipelined reads at full throughput
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 4'h0, 3'(i), 32'h0, 1'b1);
            if (i >= 1) check("pipe_valid", 32'(v_or), 32'h1);
        end
        cycle(1'b0, 4'h0, 3'd0, 32'h0, 1'b1);
        check("pipe_valid_last", 32'(v_or), 32'h1);
        cycle(1'b0, 4'h0, 3'd0, 32'h0, 1'b1);
        check("pipe_valid_end", 32'(v_or), 32'h0);

        // Reset in the middle of the clear sweep
        do_reset(1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'h0, 3'd5, 32'h0, 1'b1);
        do_reset(1);
        clear_wait();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 4'h0, 3'(i), 32'h0, 1'b1);
        cycle(1'b0, 4'h0, 3'd0, 32'h0, 1'b1);
        cycle(1'b0, 4'h0, 3'd0, 32'h0, 1'b1);
        cycle(1'b0, 4'h0, 3'd0, 32'h0, 1'b0);

        // Every predicted response must have been presented
        check("rf_drained", 32'(q_rf.size()), 32'h0);
        check("wf_drained", 32'(q_wf.size()), 32'h0);
        check("nc_drained", 32'(q_nc.size()), 32'h0);
        check("or_drained", 32'(q_or.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
